// File: rtl/dma_utils_pkg.sv
// Shared DMA types: descriptor, streamer handshake structs, AXI burst
// request and the streamer state encoding.

`ifndef DMA_NUM_DESC
`define DMA_NUM_DESC 4
`endif

package dma_utils_pkg;

    localparam int DMA_NUM_DESC_P = `DMA_NUM_DESC;
    localparam int DMA_ADDR_W     = 32;
    localparam int DMA_BYTES_W    = 32;
    localparam int DMA_IDX_W      = (DMA_NUM_DESC_P > 1) ? $clog2(DMA_NUM_DESC_P) : 1;

    // Bursts are never allowed to straddle this boundary.
    localparam int DMA_4KB        = 4096;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0]  src_addr;
        logic [DMA_ADDR_W-1:0]  dst_addr;
        logic [DMA_BYTES_W-1:0] num_bytes;
        logic                   enable;
    } s_dma_desc_t;

    typedef struct packed {
        logic                 valid;
        logic [DMA_IDX_W-1:0] idx;
    } s_dma_str_in_t;

    typedef struct packed {
        logic done;
    } s_dma_str_out_t;

    typedef struct packed {
        logic                  valid;
        logic [DMA_ADDR_W-1:0] addr;
        logic [7:0]            alen;
        logic [2:0]            size;
    } s_dma_axi_req_t;

    typedef enum logic [1:0] {
        DMA_ST_IDLE  = 2'd0,
        DMA_ST_LOAD  = 2'd1,
        DMA_ST_ISSUE = 2'd2,
        DMA_ST_DONE  = 2'd3
    } dma_str_st_t;

endpackage

// File: rtl/dma_burst_calc.sv
// Combinational burst sizing: the next burst is the smallest of the beats
// still owed, the configured burst cap and the beats left before the next
// 4KB page. The incoming address is assumed already beat-aligned.

module dma_burst_calc
    import dma_utils_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 256
) (
    input  logic [ADDR_WIDTH-1:0] i_remaining,
    input  logic [11:0]           i_addr_lo,
    output logic [8:0]            o_burst
);

    localparam int BB     = DATA_WIDTH / 8;
    localparam int LOG2BB = $clog2(BB);

    logic [12:0] w_bytes_to_4k;
    logic [12:0] w_beats_to_4k;
    logic [8:0]  w_cap;

    // Page distance is 1..4096 bytes, so 13 bits always hold it.
    assign w_bytes_to_4k = 13'(DMA_4KB) - {1'b0, i_addr_lo};
    assign w_beats_to_4k = w_bytes_to_4k >> LOG2BB;

    // Cap by the burst limit first; the result then fits 9 bits (<= 256).
    always_comb begin
        w_cap = 9'(MAX_BEATS);
        if (w_beats_to_4k < 13'(MAX_BEATS)) begin
            w_cap = w_beats_to_4k[8:0];
        end
    end

    // Remaining beats only win when strictly below the cap.
    always_comb begin
        o_burst = w_cap;
        if (i_remaining < ADDR_WIDTH'(w_cap)) begin
            o_burst = i_remaining[8:0];
        end
    end

endmodule

// File: rtl/dma_streamer.sv
// One DMA channel burst generator. Splits the selected descriptor's byte
// count into AXI bursts that respect the burst cap and 4KB pages, and
// pulses done once the last burst request has been accepted.
// ADDR_WIDTH is expected in the range 13..32.

module dma_streamer
    import dma_utils_pkg::*;
#(
    parameter int STREAMER_TYPE = 0,
    parameter int NUM_DESC      = `DMA_NUM_DESC,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_BEATS     = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  s_dma_desc_t    dma_desc_i [NUM_DESC],
    input  logic           dma_abort_i,
    input  s_dma_str_in_t  dma_stream_i,
    output s_dma_str_out_t dma_stream_o,
    output s_dma_axi_req_t dma_axi_req_o,
    input  logic           dma_axi_req_ready_i,
    output logic           dma_busy_o
);

    localparam int BB     = DATA_WIDTH / 8;
    localparam int LOG2BB = $clog2(BB);
    localparam int IDX_W  = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BB - 1));

    dma_str_st_t           r_state;
    dma_str_st_t           w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_remaining;
    logic [8:0]            r_burst;
    logic                  r_abort;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [7:0]            r_req_alen;
    logic [2:0]            r_req_size;

    logic [IDX_W-1:0]      w_idx;
    logic [ADDR_WIDTH-1:0] w_start_addr;
    logic [ADDR_WIDTH-1:0] w_beats_total;
    logic [8:0]            w_burst;
    logic                  w_last_burst;
    logic                  w_req_valid;
    logic                  w_done;
    logic [NUM_DESC-1:0]   w_unused_desc;

    assign w_idx = IDX_W'(dma_stream_i.idx);

    // Only one of the two addresses matters to a given channel; enable is
    // qualified by the control FSM before a start is issued.
    for (genvar g = 0; g < NUM_DESC; g++) begin : g_unused
        if (STREAMER_TYPE == 0) begin : g_rd
            assign w_unused_desc[g] = dma_desc_i[g].enable ^ (^dma_desc_i[g].dst_addr);
        end else begin : g_wr
            assign w_unused_desc[g] = dma_desc_i[g].enable ^ (^dma_desc_i[g].src_addr);
        end
    end

    // Select the start address and beat count of the requested descriptor.
    always_comb begin
        w_start_addr  = '0;
        w_beats_total = '0;
        if (int'(w_idx) < NUM_DESC) begin
            if (STREAMER_TYPE == 0) begin
                w_start_addr = ADDR_WIDTH'(dma_desc_i[w_idx].src_addr) & ALIGN_MASK;
            end else begin
                w_start_addr = ADDR_WIDTH'(dma_desc_i[w_idx].dst_addr) & ALIGN_MASK;
            end
            // Trailing bytes that do not fill a whole beat are dropped.
            w_beats_total = ADDR_WIDTH'(dma_desc_i[w_idx].num_bytes >> LOG2BB);
        end
    end

    dma_burst_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BEATS  (MAX_BEATS)
    ) u_burst_calc (
        .i_remaining (r_remaining),
        .i_addr_lo   (r_addr[11:0]),
        .o_burst     (w_burst)
    );

    assign w_last_burst = (r_remaining == ADDR_WIDTH'(r_burst));

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            DMA_ST_IDLE: begin
                if (dma_stream_i.valid) begin
                    w_state_nxt = DMA_ST_LOAD;
                end
            end
            DMA_ST_LOAD: begin
                w_state_nxt = (r_remaining == '0) ? DMA_ST_DONE : DMA_ST_ISSUE;
            end
            DMA_ST_ISSUE: begin
                w_req_valid = 1'b1;
                // An abort never pulls a raised request; it only stops the next one.
                if (dma_axi_req_ready_i) begin
                    if (w_last_burst || r_abort || dma_abort_i) begin
                        w_state_nxt = DMA_ST_DONE;
                    end else begin
                        w_state_nxt = DMA_ST_LOAD;
                    end
                end
            end
            DMA_ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = DMA_ST_IDLE;
            end
            default: begin
                w_state_nxt = DMA_ST_IDLE;
            end
        endcase
    end

    // State, transfer progress and registered request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= DMA_ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_burst     <= '0;
            r_abort     <= 1'b0;
            r_req_addr  <= '0;
            r_req_alen  <= '0;
            r_req_size  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                DMA_ST_IDLE: begin
                    // Descriptor contents are captured here and nowhere else.
                    if (dma_stream_i.valid) begin
                        r_addr      <= w_start_addr;
                        r_remaining <= w_beats_total;
                        r_abort     <= dma_abort_i;
                    end
                end
                DMA_ST_LOAD: begin
                    r_abort <= r_abort | dma_abort_i;
                    if (r_remaining != '0) begin
                        r_burst    <= w_burst;
                        r_req_addr <= r_addr;
                        r_req_alen <= 8'(w_burst - 9'd1);
                        r_req_size <= 3'(LOG2BB);
                    end
                end
                DMA_ST_ISSUE: begin
                    r_abort <= r_abort | dma_abort_i;
                    // Progress advances only on the handshake; address wraps naturally.
                    if (dma_axi_req_ready_i) begin
                        r_addr      <= r_addr + (ADDR_WIDTH'(r_burst) << LOG2BB);
                        r_remaining <= r_remaining - ADDR_WIDTH'(r_burst);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dma_axi_req_o = '{
        valid: w_req_valid,
        addr:  DMA_ADDR_W'(r_req_addr),
        alen:  r_req_alen,
        size:  r_req_size
    };
    assign dma_stream_o = '{done: w_done};
    assign dma_busy_o   = (r_state != DMA_ST_IDLE);

endmodule

// File: tb/tb_dma_streamer.sv
// Directed and randomized bench for the read-side dma_streamer
// (32-bit data, 256-beat cap) against a burst-list reference model.

module tb_dma_streamer;
    import dma_utils_pkg::*;

    localparam int NDESC = 4;

    logic           clk = 1'b0;
    logic           rst;
    s_dma_desc_t    desc [NDESC];
    logic           abort;
    s_dma_str_in_t  sin;
    s_dma_str_out_t sout;
    s_dma_axi_req_t req;
    logic           ready;
    logic           busy;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] exp_addr_q[$];
    int          exp_alen_q[$];

    always #5 clk = ~clk;

    dma_streamer #(
        .STREAMER_TYPE (0),
        .NUM_DESC      (NDESC),
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .MAX_BEATS     (256)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .dma_desc_i          (desc),
        .dma_abort_i         (abort),
        .dma_stream_i        (sin),
        .dma_stream_o        (sout),
        .dma_axi_req_o       (req),
        .dma_axi_req_ready_i (ready),
        .dma_busy_o          (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected burst list: walk the byte count page by page with plain arithmetic.
    task automatic build_model(input logic [31:0] start, input logic [31:0] bytes, input bit one_burst);
        logic [31:0] a;
        longint rem, to4k, b;
        exp_addr_q.delete();
        exp_alen_q.delete();
        a   = start & 32'hFFFF_FFFC;
        rem = longint'(bytes) / 4;
        while (rem > 0) begin
            to4k = (4096 - longint'(a % 32'd4096)) / 4;
            b = rem;
            if (b > 256)  b = 256;
            if (b > to4k) b = to4k;
            exp_addr_q.push_back(a);
            exp_alen_q.push_back(int'(b) - 1);
            a   = a + 32'(b * 4);
            rem = rem - b;
            if (one_burst) break;
        end
    endtask

    // rmode: 0 ready always, 1 random ready, 2 ready low until t=12.
    // amode: 0 no abort, 1 abort raised during first ISSUE, 2 abort high at start.
    task automatic run_xfer(input string name, input logic [31:0] src, input logic [31:0] bytes,
                            input int rmode, input int amode);
        int idx, t, exp_valid_t, exp_done_t;
        bit v;
        idx = $urandom_range(0, NDESC - 1);
        for (int i = 0; i < NDESC; i++) begin
            desc[i].src_addr  = $urandom;
            desc[i].dst_addr  = $urandom;
            desc[i].num_bytes = $urandom_range(0, 8192);
            desc[i].enable    = 1'b1;
        end
        desc[idx].src_addr  = src;
        desc[idx].dst_addr  = ~src;
        desc[idx].num_bytes = bytes;
        build_model(src, bytes, amode != 0);

        @(negedge clk);
        sin.valid = 1'b1;
        sin.idx   = DMA_IDX_W'(idx);
        if (amode == 2) abort = 1'b1;
        @(negedge clk);
        sin.valid = 1'b0;
        sin.idx   = '0;
        // Descriptor edits after the start must not affect the transfer.
        for (int i = 0; i < NDESC; i++) begin
            desc[i].src_addr  = $urandom;
            desc[i].num_bytes = $urandom;
        end

        t           = 1;
        exp_valid_t = 2;
        exp_done_t  = (exp_addr_q.size() == 0) ? 2 : -1;
        while (1) begin
            v = (exp_addr_q.size() != 0) && (t >= exp_valid_t);
            check({name, ".valid"}, 64'(req.valid), 64'(v));
            check({name, ".done"}, 64'(sout.done), 64'(exp_done_t == t));
            check({name, ".busy"}, 64'(busy), 64'((exp_done_t < 0) || (t <= exp_done_t)));
            if (v && req.valid) begin
                check({name, ".addr"}, 64'(req.addr), 64'(exp_addr_q[0]));
                check({name, ".alen"}, 64'(req.alen), 64'(exp_alen_q[0]));
                check({name, ".size"}, 64'(req.size), 64'(2));
            end
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = 1'($urandom_range(0, 1));
                default: ready = (t >= 12);
            endcase
            if (amode == 1 && t == 2) begin
                abort = 1'b1;
                ready = 1'b0;
            end
            if (v && ready) begin
                void'(exp_addr_q.pop_front());
                void'(exp_alen_q.pop_front());
                if (exp_addr_q.size() == 0) exp_done_t = t + 1;
                else                        exp_valid_t = t + 2;
            end
            if (exp_done_t >= 0 && t > exp_done_t) break;
            if (t > 6000) begin
                check({name, ".budget"}, 64'(t), 64'(6000));
                break;
            end
            @(negedge clk);
            t++;
        end
        ready = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        abort = 1'b0;
        ready = 1'b0;
        sin   = '0;
        for (int i = 0; i < NDESC; i++) desc[i] = '0;

        repeat (3) @(negedge clk);
        check("rst.valid", 64'(req.valid), 64'(0));
        check("rst.addr",  64'(req.addr),  64'(0));
        check("rst.alen",  64'(req.alen),  64'(0));
        check("rst.size",  64'(req.size),  64'(0));
        check("rst.done",  64'(sout.done), 64'(0));
        check("rst.busy",  64'(busy),      64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle.busy", 64'(busy), 64'(0));

        run_xfer("single",      32'h0000_1000, 32'd64,   0, 0);
        run_xfer("split4k",     32'h0000_0FF0, 32'd64,   0, 0);
        run_xfer("max256",      32'h0000_0000, 32'd2048, 1, 0);
        run_xfer("stall",       32'h0000_2000, 32'd256,  2, 0);
        run_xfer("abort_issue", 32'h0000_0000, 32'd4096, 0, 1);
        run_xfer("abort_idle",  32'h0000_0100, 32'd4096, 1, 2);
        run_xfer("short",       32'h0000_1234, 32'd3,    0, 0);
        run_xfer("zero",        32'h0000_5000, 32'd0,    0, 0);
        run_xfer("unaligned",   32'h0000_1003, 32'd67,   1, 0);
        run_xfer("wrap",        32'hFFFF_FF00, 32'd1024, 1, 0);

        // Reset while a request is outstanding: request dropped, no done.
        for (int i = 0; i < NDESC; i++) desc[i] = '0;
        desc[1].src_addr  = 32'h0000_3000;
        desc[1].num_bytes = 32'd1024;
        @(negedge clk);
        sin.valid = 1'b1;
        sin.idx   = DMA_IDX_W'(1);
        @(negedge clk);
        sin.valid = 1'b0;
        @(negedge clk);
        check("rstmid.pre_valid", 64'(req.valid), 64'(1));
        check("rstmid.pre_addr",  64'(req.addr),  64'(32'h3000));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid.valid", 64'(req.valid), 64'(0));
        check("rstmid.busy",  64'(busy),      64'(0));
        check("rstmid.addr",  64'(req.addr),  64'(0));
        check("rstmid.alen",  64'(req.alen),  64'(0));
        for (int k = 0; k < 6; k++) begin
            check("rstmid.done",  64'(sout.done), 64'(0));
            check("rstmid.idle",  64'(req.valid), 64'(0));
            @(negedge clk);
        end

        for (int k = 0; k < 25; k++) begin
            logic [31:0] a;
            logic [31:0] nb;
            a = $urandom;
            if (k % 3 == 0) a[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
            nb = $urandom_range(0, 6000);
            run_xfer("rand", a, nb, 1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
